// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory wait, I/O handshakes and pause
// Outputs are registered from the next state and next latched opcode so they track state without glitches.
module multicycle_control_unit #(
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       in_valid,
   input  logic       out_ack,
   input  logic       resume,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       ALUSrc,
   output logic       RegWrite,
   output logic       Branch,
   output logic       Jump,
   output logic       Jal,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUOp,
   output logic [1:0] bits_16_26,
   output logic       print,
   output logic       in,
   output logic       pause,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM    = 4'd4,
      S_WB     = 4'd5,
      S_IO     = 4'd6,
      S_PAUSED = 4'd7,
      S_JMP    = 4'd8
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_PRINT = 6'b111111;
   localparam logic [5:0] OP_INPUT = 6'b111000;
   localparam logic [5:0] OP_PAUSE = 6'b000111;

   localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef struct packed {
      logic       pcw;
      logic       irw;
      logic       mr;
      logic       mw;
      logic       alusrc;
      logic       rw;
      logic       br;
      logic       jmp;
      logic       jal;
      logic [1:0] rd;
      logic [1:0] m2r;
      logic [1:0] aluop;
      logic [1:0] b1626;
      logic       pr;
      logic       inn;
      logic       pa;
   } ctl_t;

   state_t           cur, state_n;
   logic [5:0]       op_q, op_n;
   logic [CNT_W-1:0] cnt;
   ctl_t             ctl;
   logic             op_legal;

   function automatic ctl_t outs(input state_t s, input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.pcw = 1'b1;
            c.irw = 1'b1;
            c.mr  = 1'b1;
         end
         S_EXEC: begin
            case (op)
               OP_ADDI: begin
                  c.alusrc = 1'b1;
                  c.b1626  = 2'b11;
               end
               OP_LW, OP_SW: begin
                  c.aluop  = 2'b11;
                  c.alusrc = 1'b1;
                  c.b1626  = 2'b11;
               end
               OP_BEQ: begin
                  c.br    = 1'b1;
                  c.aluop = 2'b10;
                  c.b1626 = 2'b11;
                  c.pcw   = 1'b1;
               end
               OP_BNE: begin
                  c.br    = 1'b1;
                  c.b1626 = 2'b11;
                  c.pcw   = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            c.mr = (op == OP_LW);
            c.mw = (op == OP_SW);
         end
         S_WB: begin
            c.rw = 1'b1;
            case (op)
               OP_R:  c.rd = 2'b01;
               OP_LW: c.m2r = 2'b01;
               OP_LUI: begin
                  c.m2r   = 2'b10;
                  c.b1626 = 2'b11;
               end
               OP_INPUT: begin
                  c.rd    = 2'b10;
                  c.m2r   = 2'b10;
                  c.b1626 = 2'b01;
               end
               default: ;
            endcase
         end
         S_JMP: begin
            c.pcw = 1'b1;
            if (op == OP_JAL) begin
               c.jal    = 1'b1;
               c.aluop  = 2'b01;
               c.alusrc = 1'b1;
            end else begin
               c.jmp = 1'b1;
            end
         end
         S_IO: begin
            if (op == OP_PRINT) begin
               c.pr = 1'b1;
            end else begin
               c.inn   = 1'b1;
               c.rd    = 2'b10;
               c.m2r   = 2'b10;
               c.b1626 = 2'b01;
            end
         end
         S_PAUSED: c.pa = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      op_legal = 1'b1;
      case (opcode)
         OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI,
         OP_J, OP_JAL, OP_PRINT, OP_INPUT, OP_PAUSE: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_n = cur;
      op_n    = op_q;
      case (cur)
         S_RESET:  state_n = S_FETCH;
         S_FETCH:  state_n = S_DECODE;
         S_DECODE: begin
            op_n = opcode;
            case (opcode)
               OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_n = S_EXEC;
               OP_LUI:             state_n = S_WB;
               OP_J, OP_JAL:       state_n = S_JMP;
               OP_PRINT, OP_INPUT: state_n = S_IO;
               OP_PAUSE:           state_n = S_PAUSED;
               default:            state_n = S_FETCH;
            endcase
         end
         S_EXEC: begin
            if (op_q == OP_LW || op_q == OP_SW)
               state_n = S_MEM;
            else if (op_q == OP_BEQ || op_q == OP_BNE)
               state_n = S_FETCH;
            else
               state_n = S_WB;
         end
         S_MEM: begin
            if (cnt == MEM_LAST)
               state_n = (op_q == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:  state_n = S_FETCH;
         S_JMP: state_n = S_FETCH;
         S_IO: begin
            if (op_q == OP_PRINT) begin
               if (out_ack) state_n = S_FETCH;
            end else if (in_valid) begin
               state_n = S_WB;
            end
         end
         S_PAUSED: if (resume) state_n = S_FETCH;
         default:  state_n = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur  <= S_RESET;
         op_q <= '0;
         cnt  <= '0;
         ctl  <= '0;
      end else begin
         cur  <= state_n;
         op_q <= op_n;
         ctl  <= outs(state_n, op_n);
         // Held at zero outside MEM so every MEM entry starts counting from 0.
         if (cur == S_MEM)
            cnt <= cnt + CNT_W'(1);
         else
            cnt <= '0;
      end
   end

   assign PCWrite    = ctl.pcw;
   assign IRWrite    = ctl.irw;
   assign MemRead    = ctl.mr;
   assign MemWrite   = ctl.mw;
   assign ALUSrc     = ctl.alusrc;
   assign RegWrite   = ctl.rw;
   assign Branch     = ctl.br;
   assign Jump       = ctl.jmp;
   assign Jal        = ctl.jal;
   assign RegDst     = ctl.rd;
   assign MemtoReg   = ctl.m2r;
   assign ALUOp      = ctl.aluop;
   assign bits_16_26 = ctl.b1626;
   assign print      = ctl.pr;
   assign in         = ctl.inn;
   assign pause      = ctl.pa;
   assign illegal    = (cur == S_DECODE) && !op_legal;
   assign state      = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
// Each instruction is expanded into its expected per-cycle trace; a negedge monitor checks every cycle.
module tb_multicycle_control_unit;

   localparam int ML = 3;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_PRINT = 6'b111111;
   localparam logic [5:0] OP_INPUT = 6'b111000;
   localparam logic [5:0] OP_PAUSE = 6'b000111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, mr, mw, alusrc, rw, br, jmp, jal;
      logic [1:0] rd, m2r, aluop, b1626;
      logic       pr, inn, pa, ill;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       in_valid = 1'b0, out_ack = 1'b0, resume = 1'b0;
   logic       PCWrite, IRWrite, MemRead, MemWrite, ALUSrc, RegWrite, Branch, Jump, Jal;
   logic [1:0] RegDst, MemtoReg, ALUOp, bits_16_26;
   logic       print, in, pause, illegal;
   logic [3:0] state;

   rec_t  exp_q[$];
   string tag_q[$];
   rec_t  tr_q[$];
   int    hk_q[$];
   bit    hv_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;

   logic [5:0] legal_ops [12] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI,
                                  OP_J, OP_JAL, OP_PRINT, OP_INPUT, OP_PAUSE};

   multicycle_control_unit #(.MEM_LATENCY(ML), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .in_valid(in_valid), .out_ack(out_ack),
      .resume(resume), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Branch(Branch),
      .Jump(Jump), .Jal(Jal), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
      .bits_16_26(bits_16_26), .print(print), .in(in), .pause(pause), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(input logic [5:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic rec_t mk(input logic [3:0] st);
      rec_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   function automatic void add(input rec_t r, input int k, input bit v);
      tr_q.push_back(r);
      hk_q.push_back(k);
      hv_q.push_back(v);
   endfunction

   // hk: 0 = no handshake owned this cycle, 1 = in_valid, 2 = out_ack, 3 = resume
   task automatic step(input rec_t r, input string tag, input int hk, input bit hv,
                       input bit is_dec, input logic [5:0] op, input bit rst);
      @(posedge clk);
      #1;
      rst_n    = rst;
      opcode   = is_dec ? op : 6'($urandom);
      in_valid = 1'($urandom);
      out_ack  = 1'($urandom);
      resume   = 1'($urandom);
      case (hk)
         1: in_valid = hv;
         2: out_ack  = hv;
         3: resume   = hv;
         default: ;
      endcase
      exp_q.push_back(r);
      tag_q.push_back(tag);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(mk(0), "reset", 0, 1'b0, 1'b0, 6'd0, 1'b0);
      step(mk(0), "reset_release", 0, 1'b0, 1'b0, 6'd0, 1'b1);
   endtask

   // Expected trace built from the per-instruction cycle lists; w = extra wait cycles for IO/pause.
   task automatic run_instr(input logic [5:0] op, input int w, input int rst_at, input string tag);
      rec_t r;
      tr_q.delete(); hk_q.delete(); hv_q.delete();
      r = mk(1); r.pcw = 1; r.irw = 1; r.mr = 1; add(r, 0, 0);
      r = mk(2); r.ill = !is_legal(op); add(r, 0, 0);
      case (op)
         OP_R: begin
            add(mk(3), 0, 0);
            r = mk(5); r.rw = 1; r.rd = 2'b01; add(r, 0, 0);
         end
         OP_ADDI: begin
            r = mk(3); r.alusrc = 1; r.b1626 = 2'b11; add(r, 0, 0);
            r = mk(5); r.rw = 1; add(r, 0, 0);
         end
         OP_LW, OP_SW: begin
            r = mk(3); r.aluop = 2'b11; r.alusrc = 1; r.b1626 = 2'b11; add(r, 0, 0);
            for (int i = 0; i < ML; i++) begin
               r = mk(4); r.mr = (op == OP_LW); r.mw = (op == OP_SW); add(r, 0, 0);
            end
            if (op == OP_LW) begin
               r = mk(5); r.rw = 1; r.m2r = 2'b01; add(r, 0, 0);
            end
         end
         OP_BEQ, OP_BNE: begin
            r = mk(3); r.br = 1; r.b1626 = 2'b11; r.pcw = 1;
            r.aluop = (op == OP_BEQ) ? 2'b10 : 2'b00;
            add(r, 0, 0);
         end
         OP_LUI: begin
            r = mk(5); r.rw = 1; r.m2r = 2'b10; r.b1626 = 2'b11; add(r, 0, 0);
         end
         OP_J: begin
            r = mk(8); r.pcw = 1; r.jmp = 1; add(r, 0, 0);
         end
         OP_JAL: begin
            r = mk(8); r.pcw = 1; r.jal = 1; r.aluop = 2'b01; r.alusrc = 1; add(r, 0, 0);
         end
         OP_PRINT: begin
            for (int i = 0; i <= w; i++) begin
               r = mk(6); r.pr = 1; add(r, 2, i == w);
            end
         end
         OP_INPUT: begin
            for (int i = 0; i <= w; i++) begin
               r = mk(6); r.inn = 1; r.rd = 2'b10; r.m2r = 2'b10; r.b1626 = 2'b01;
               add(r, 1, i == w);
            end
            r = mk(5); r.rw = 1; r.rd = 2'b10; r.m2r = 2'b10; r.b1626 = 2'b01; add(r, 0, 0);
         end
         OP_PAUSE: begin
            for (int i = 0; i <= w; i++) begin
               r = mk(7); r.pa = 1; add(r, 3, i == w);
            end
         end
         default: ;
      endcase
      foreach (tr_q[i]) begin
         if (i == rst_at) begin
            step(mk(0), {tag, "_midreset"}, 0, 1'b0, 1'b0, op, 1'b0);
            do_reset(1);
            return;
         end
         step(tr_q[i], tag, hk_q[i], hv_q[i], i == 1, op, 1'b1);
      end
   endtask

   always @(negedge clk) begin
      rec_t e, a;
      string t;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {state, PCWrite, IRWrite, MemRead, MemWrite, ALUSrc, RegWrite, Branch, Jump, Jal,
              RegDst, MemtoReg, ALUOp, bits_16_26, print, in, pause, illegal};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %h required %h", t, cyc, a, e);
         end
      end
   end

   initial begin
      logic [5:0] op;
      int         w, ra;
      do_reset(3);
      run_instr(OP_R, 0, -1, "rtype");
      run_instr(OP_ADDI, 0, -1, "addi");
      run_instr(OP_LW, 0, -1, "lw");
      run_instr(OP_SW, 0, -1, "sw");
      run_instr(OP_INPUT, 5, -1, "input_wait5");
      run_instr(OP_PRINT, 0, -1, "print_ack_high");
      run_instr(6'b010101, 0, -1, "illegal");
      run_instr(OP_PAUSE, 3, -1, "pause");
      run_instr(OP_LW, 0, 4, "lw_reset");
      run_instr(OP_BEQ, 0, -1, "beq");
      run_instr(OP_BNE, 0, -1, "bne");
      run_instr(OP_LUI, 0, -1, "lui");
      run_instr(OP_J, 0, -1, "j");
      run_instr(OP_JAL, 0, -1, "jal");
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = 6'($urandom); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 11)];
         end
         w  = int'($urandom_range(0, 6));
         ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 8)) : -1;
         run_instr(op, w, ra, "random");
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
